// File: rtl/punc_debug_dumper_if.sv
// Snapshot word stream from the debug dumper: valid/ready handshake carrying
// a 16-bit data word together with its type tag and index.
interface punc_debug_dumper_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic [15:0] out_index;

  modport master (
    output out_valid,
    output out_data,
    output out_tag,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/punc_debug_dumper.sv
// Debug-host engine: walks PC, R0-R7 and a memory window through the PUnC debug
// read ports and serialises them, followed by an end marker, onto a word stream.
module punc_debug_dumper #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_debug_addr,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] pc_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] mem_debug_data,
  punc_debug_dumper_if.master stream
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT, S_DONE} state_t;
  typedef enum logic [1:0] {P_PC, P_RF, P_MEM, P_END} phase_t;

  localparam logic [1:0] SETTLE_LAST = 2'(MEM_LAT - 1);

  state_t      state_reg;
  phase_t      phase_reg;
  logic [15:0] cnt_reg;
  logic [1:0]  settle_reg;
  logic [15:0] base_reg;
  logic [15:0] count_reg;
  logic [15:0] mem_addr_reg;
  logic [2:0]  rf_addr_reg;
  logic        out_valid_reg;
  logic [15:0] out_data_reg;
  logic [1:0]  out_tag_reg;
  logic [15:0] out_index_reg;
  logic        busy_reg;
  logic        done_reg;

  // Debug addresses are updated together with the item counter, so they are
  // already stable on the first settle cycle of the item they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      phase_reg     <= P_PC;
      cnt_reg       <= '0;
      settle_reg    <= '0;
      base_reg      <= '0;
      count_reg     <= '0;
      mem_addr_reg  <= '0;
      rf_addr_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
      out_index_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            base_reg   <= base_addr;
            count_reg  <= word_count;
            phase_reg  <= P_PC;
            cnt_reg    <= '0;
            settle_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_reg == SETTLE_LAST) begin
            settle_reg    <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= S_EMIT;
            case (phase_reg)
              P_PC: begin
                out_data_reg  <= pc_debug_data;
                out_tag_reg   <= 2'b00;
                out_index_reg <= '0;
              end
              P_RF: begin
                out_data_reg  <= rf_debug_data;
                out_tag_reg   <= 2'b01;
                out_index_reg <= {13'd0, cnt_reg[2:0]};
              end
              P_MEM: begin
                out_data_reg  <= mem_debug_data;
                out_tag_reg   <= 2'b10;
                out_index_reg <= mem_addr_reg;
              end
              P_END: begin
                out_data_reg  <= count_reg;
                out_tag_reg   <= 2'b11;
                out_index_reg <= '0;
              end
            endcase
          end else begin
            settle_reg <= settle_reg + 2'd1;
          end
        end
        S_EMIT: begin
          if (stream.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_SETTLE;
            case (phase_reg)
              P_PC: begin
                phase_reg   <= P_RF;
                cnt_reg     <= '0;
                rf_addr_reg <= 3'd0;
              end
              P_RF: begin
                if (cnt_reg[2:0] == 3'd7) begin
                  cnt_reg <= '0;
                  if (count_reg == 16'd0) begin
                    phase_reg <= P_END;
                  end else begin
                    phase_reg    <= P_MEM;
                    mem_addr_reg <= base_reg;
                  end
                end else begin
                  cnt_reg     <= cnt_reg + 16'd1;
                  rf_addr_reg <= cnt_reg[2:0] + 3'd1;
                end
              end
              P_MEM: begin
                if (cnt_reg == count_reg - 16'd1) begin
                  phase_reg <= P_END;
                  cnt_reg   <= '0;
                end else begin
                  cnt_reg      <= cnt_reg + 16'd1;
                  mem_addr_reg <= base_reg + cnt_reg + 16'd1;
                end
              end
              P_END: begin
                state_reg <= S_DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            endcase
          end
        end
        S_DONE: state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy             = busy_reg;
  assign done             = done_reg;
  assign mem_debug_addr   = mem_addr_reg;
  assign rf_debug_addr    = rf_addr_reg;
  assign stream.out_valid = out_valid_reg;
  assign stream.out_data  = out_data_reg;
  assign stream.out_tag   = out_tag_reg;
  assign stream.out_index = out_index_reg;

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Scoreboard bench for punc_debug_dumper: one dumper with MEM_LAT=1 and one with
// MEM_LAT=3 (behind a pipelined debug-data model), observed through a mux.
module tb_punc_debug_dumper;

  localparam logic [15:0] PC_VAL = 16'h3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] word_count = '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  logic [33:0] sb[$];

  logic        start1, start3;
  logic        busy1, done1, busy3, done3;
  logic [15:0] mem_addr1, mem_addr3;
  logic [2:0]  rf_addr1, rf_addr3;
  logic [15:0] rf_data1, mem_data1, rf_data3, mem_data3;
  logic [2:0]  rf_d1, rf_d2;
  logic [15:0] mem_d1, mem_d2;

  assign start1 = start & ~sel;
  assign start3 = start & sel;

  // Debug port models: Rn = 0x1110*n, mem[a] = a + 0x7000 (0x3000 -> 0xA000).
  assign rf_data1  = 16'h1110 * {13'd0, rf_addr1};
  assign mem_data1 = mem_addr1 + 16'h7000;
  always @(posedge clk) begin
    rf_d1  <= rf_addr3;
    rf_d2  <= rf_d1;
    mem_d1 <= mem_addr3;
    mem_d2 <= mem_d1;
  end
  assign rf_data3  = 16'h1110 * {13'd0, rf_d2};
  assign mem_data3 = mem_d2 + 16'h7000;

  punc_debug_dumper_if s1();
  punc_debug_dumper_if s3();
  assign s1.out_ready = out_ready;
  assign s3.out_ready = out_ready;

  punc_debug_dumper #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .word_count(word_count),
    .busy(busy1), .done(done1), .mem_debug_addr(mem_addr1), .rf_debug_addr(rf_addr1),
    .pc_debug_data(PC_VAL), .rf_debug_data(rf_data1), .mem_debug_data(mem_data1),
    .stream(s1)
  );

  punc_debug_dumper #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .base_addr(base_addr), .word_count(word_count),
    .busy(busy3), .done(done3), .mem_debug_addr(mem_addr3), .rf_debug_addr(rf_addr3),
    .pc_debug_data(PC_VAL), .rf_debug_data(rf_data3), .mem_debug_data(mem_data3),
    .stream(s3)
  );

  logic        o_valid, o_busy, o_done;
  logic [15:0] o_data, o_index, o_mem_addr;
  logic [1:0]  o_tag;
  logic [2:0]  o_rf_addr;
  logic [55:0] all_out;
  assign o_valid    = sel ? s3.out_valid : s1.out_valid;
  assign o_data     = sel ? s3.out_data  : s1.out_data;
  assign o_tag      = sel ? s3.out_tag   : s1.out_tag;
  assign o_index    = sel ? s3.out_index : s1.out_index;
  assign o_busy     = sel ? busy3 : busy1;
  assign o_done     = sel ? done3 : done1;
  assign o_mem_addr = sel ? mem_addr3 : mem_addr1;
  assign o_rf_addr  = sel ? rf_addr3 : rf_addr1;
  assign all_out    = {o_valid, o_busy, o_done, o_tag, o_rf_addr, o_mem_addr, o_data, o_index};

  // One full dump: expected words are queued at start and popped on each transfer.
  task automatic run_stream(input string name, input bit use3, input logic [15:0] base,
                            input logic [15:0] wc, input int ready_pct, input int poke_busy_at,
                            input int abort_at, input bit poke_done);
    int lat, e0, last_edge, xfers;
    bit prev_stall, finished, aborted, poked;
    logic [33:0] prev_w, cur_w, exp_w;
    lat = use3 ? 3 : 1;
    xfers = 0; last_edge = 0; prev_stall = 0; finished = 0; aborted = 0; poked = 0;
    prev_w = '0;
    sb.delete();
    sb.push_back({2'b00, 16'h0000, PC_VAL});
    for (int n = 0; n < 8; n++) sb.push_back({2'b01, 16'(n), 16'(16'h1110 * n)});
    for (int k = 0; k < int'(wc); k++)
      sb.push_back({2'b10, 16'(base + 16'(k)), 16'(base + 16'(k) + 16'h7000)});
    sb.push_back({2'b11, 16'h0000, wc});

    @(negedge clk);
    sel = use3; out_ready = 1'b0; base_addr = base; word_count = wc; start = 1'b1;
    #1;
    compared++;
    if (o_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s busy_before_start: got %b expected 0", name, o_busy);
    end
    e0 = cyc + 1;

    for (int it = 0; it < 4000 && !finished; it++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_busy_at > 0 && !poked && xfers == poke_busy_at) begin
        start = 1'b1;
        poked = 1;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      cur_w = {o_tag, o_index, o_data};
      if (prev_stall) begin
        compared++;
        if (o_valid !== 1'b1 || cur_w !== prev_w) begin
          mismatched++;
          $display("FAIL %s stall_hold: got valid=%b word=%h expected valid=1 word=%h",
                   name, o_valid, cur_w, prev_w);
        end
      end
      if (o_done === 1'b1) begin
        finished = 1;
        compared++;
        if (sb.size() != 0) begin
          mismatched++;
          $display("FAIL %s done_early: got %0d words outstanding expected 0", name, sb.size());
        end
        compared++;
        if (o_busy !== 1'b0) begin
          mismatched++;
          $display("FAIL %s busy_in_done: got %b expected 0", name, o_busy);
        end
        compared++;
        if (cyc != last_edge) begin
          mismatched++;
          $display("FAIL %s done_timing: got cycle %0d expected %0d", name, cyc, last_edge);
        end
        if (ready_pct >= 100) begin
          compared++;
          if (last_edge != e0 + (lat + 1) * (10 + int'(wc))) begin
            mismatched++;
            $display("FAIL %s final_edge: got E0+%0d expected E0+%0d", name,
                     last_edge - e0, (lat + 1) * (10 + int'(wc)));
          end
        end
        if (poke_done) start = 1'b1;
      end else begin
        compared++;
        if (o_busy !== 1'b1) begin
          mismatched++;
          $display("FAIL %s busy_high: got %b expected 1 at cycle %0d", name, o_busy, cyc);
        end
        if (o_valid === 1'b1 && out_ready) begin
          xfers++;
          last_edge = cyc + 1;
          $display("%s: word %0d tag=%b index=%h data=%h", name, xfers, o_tag, o_index, o_data);
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL %s extra_word: got %h expected no word", name, cur_w);
          end else begin
            exp_w = sb.pop_front();
            if (cur_w !== exp_w) begin
              mismatched++;
              $display("FAIL %s word%0d: got tag/index/data %h expected %h", name, xfers, cur_w, exp_w);
            end
          end
          if (abort_at > 0 && xfers == abort_at) begin
            @(negedge clk);
            start = 1'b0;
            rst = 1'b0;
            #1;
            compared++;
            if (all_out !== 56'd0) begin
              mismatched++;
              $display("FAIL %s abort_zero: got outputs %h expected 0", name, all_out);
            end
            repeat (3) begin
              @(negedge clk);
              compared++;
              if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                mismatched++;
                $display("FAIL %s abort_no_done: got done=%b busy=%b expected 0/0", name, o_done, o_busy);
              end
            end
            rst = 1'b1;
            finished = 1;
            aborted = 1;
          end
        end
        prev_stall = (o_valid === 1'b1) && !out_ready;
        prev_w = cur_w;
      end
    end

    if (!finished) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: got no done after 4000 cycles expected done", name);
    end else if (!aborted) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      compared++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        mismatched++;
        $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, o_done, o_busy);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      compared++;
      if (all_out !== 56'd0) begin
        mismatched++;
        $display("FAIL reset_state dut%0d: got outputs %h expected 0", s, all_out);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    compared++;
    if (all_out !== 56'd0) begin
      mismatched++;
      $display("FAIL idle_after_release: got outputs %h expected 0", all_out);
    end
  endtask

  task automatic test_basic_dump();
    run_stream("basic", 1'b0, 16'h3000, 16'd4, 100, 3, 0, 1'b1);
  endtask

  task automatic test_empty_window();
    run_stream("empty", 1'b0, 16'h1234, 16'd0, 100, 0, 0, 1'b0);
  endtask

  task automatic test_wrap_around();
    run_stream("wrap", 1'b0, 16'hFFFE, 16'd4, 100, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", 1'b1, 16'h3000, 16'd4, 30, 2, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_stream("b2b_a", 1'b1, 16'h0100, 16'd2, 100, 0, 0, 1'b0);
    run_stream("b2b_b", 1'b1, 16'hFFFF, 16'd3, 100, 0, 0, 1'b0);
  endtask

  task automatic test_abort_restart();
    run_stream("abort", 1'b0, 16'h3000, 16'd4, 100, 2, 5, 1'b0);
    run_stream("restart", 1'b0, 16'h3000, 16'd4, 100, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_empty_window();
    test_wrap_around();
    test_backpressure();
    test_back_to_back();
    test_abort_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/punc_debug_dumper.md
# punc_debug_dumper

Debug-host engine on the far side of the PUnC debug read ports. On a start pulse it drives `mem_debug_addr` and `rf_debug_addr`, samples `pc_debug_data`, `rf_debug_data` and `mem_debug_data`, and serialises a snapshot onto a valid/ready word stream for a bench or host link. The snapshot is PC, then R0–R7, then a programmable memory window, then an end marker. It is intended for use while the core is halted or stalled; there is no coherence guarantee against a running core.

## Interface
- `MEM_LAT`, default 1: cycles between driving a debug address and sampling its data. Legal range 1..3.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `base_addr`  in  16  first memory word of the window; captured at start.
- `word_count`  in  16  number of memory words to dump; captured at start; 0 means no memory phase.
- `busy`  out  1  high from the cycle after start acceptance until the end marker is transferred.
- `done`  out  1  one-cycle pulse after the end marker transfer.
- `mem_debug_addr`  out  16  memory debug read address.
- `rf_debug_addr`  out  3  register-file debug read address.
- `pc_debug_data`  in  16  PC value from the core.
- `rf_debug_data`  in  16  register-file read data.
- `mem_debug_data`  in  16  memory read data.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  stream sink ready.
- `out_data`  out  16  stream word.
- `out_tag`  out  2  word type: 00 PC, 01 register, 10 memory, 11 end marker.
- `out_index`  out  16  index for the word:
  - register number (zero-extended) for tag 01,
  - memory address for tag 10,
  - 0 for tags 00 and 11.

## Operation
- **FSM states:** IDLE, SETTLE, EMIT, DONE.
- **Phase register:** PC, RF, MEM, END. A 16-bit item counter and a 2-bit settle counter sit alongside it.
- **IDLE:**
  - `start`=1 captures `base_addr` and `word_count`, sets phase PC and counter 0, and goes to SETTLE.
  - `start` in any other state is ignored.
- **SETTLE:**
  - Debug addresses are held constant for MEM_LAT cycles.
  - On the last settle cycle the phase's data is registered into `out_data`, with `out_tag` and `out_index` set. Then go to EMIT.
- **EMIT:**
  - `out_valid`=1 is held, with data, tag and index stable, until `out_valid`&`out_ready` at a rising edge.
  - On transfer, advance:
    - PC → RF with counter 0.
    - RF counter 7 → MEM, or → END if the captured `word_count`=0.
    - MEM counter `word_count`−1 → END.
    - END → DONE.
    - Otherwise increment the counter and return to SETTLE.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- **Address generation:**
  - `rf_debug_addr` = counter[2:0] during the RF phase.
  - `mem_debug_addr` = (`base_addr` + counter) mod 2^16 during the MEM phase, wrapping from 0xFFFF to 0x0000.
  - Both addresses hold their last value in all other phases.
- **End marker:** `out_data` = captured `word_count`, `out_index`=0, `out_tag`=11.
- **Reset:** asynchronous assertion mid-dump aborts immediately with no end marker. All outputs are 0 (`out_valid`, `busy`, `done`, addresses, data, tag, index), the FSM is in IDLE, and all counters are 0.

## Timing
- `start` sampled at edge E0 → `busy`=1 and SETTLE from E0.
- Each item spends MEM_LAT cycles in SETTLE and at least 1 cycle in EMIT.
- With `out_ready` held high, throughput is MEM_LAT+1 cycles per word.
- Item count = 10 + `word_count`. The final transfer is at E0 + (MEM_LAT+1)·(10+`word_count`).
- `done` is high in the cycle after the final transfer. `busy` falls in that same cycle.
- `out_valid` never deasserts without a transfer. `out_data` never changes while `out_valid`=1 and `out_ready`=0.
- No combinational path from `out_ready` to `out_valid` or `out_data`.
- `start` asserted in the DONE cycle is ignored. The earliest new start is the following cycle (IDLE).

## Test plan
- **Basic dump:** MEM_LAT=1, PC=0x3000, Rn=0x1110·n, mem[0x3000..0x3003]=0xA000..0xA003, `base_addr`=0x3000, `word_count`=4, `out_ready`=1.
  - Required stream: (00,0,0x3000), (01,0..7,0x0000..0x7770), (10,0x3000..0x3003,0xA000..0xA003), (11,0,0x0004).
  - 14 words; final transfer at E28; `done` for exactly one cycle.
- **Empty window:** `word_count`=0.
  - 10 words only: PC, R0–R7, then end marker with data 0x0000. No tag 10 emitted.
- **Wrap-around:** `base_addr`=0xFFFE, `word_count`=4.
  - Memory indices 0xFFFE, 0xFFFF, 0x0000, 0x0001, each with matching data.
- **Backpressure:** random `out_ready` (≈30% high), MEM_LAT=3.
  - Same word sequence as the basic dump.
  - `out_data`/`out_tag`/`out_index` stable across every stalled cycle; no word dropped or duplicated.
- **Reset and start during busy:** pulse `start` while `busy`=1 → ignored, stream unchanged. Drop `rst` low after the 5th transfer:
  - All outputs 0 within the same cycle, no `done`.
  - After release, a new start produces a full, correct dump.
